range_image_reader: RTL and testbench
=====================================

Name: range_image_reader

Overview:
- Read-side counterpart of the range-image writer stage.
- On a start pulse, scans the range-image BRAM in row-major order and streams each pixel out as (x, y, range) on a valid/ready interface with end-of-row and end-of-frame markers.
- Optionally zeroes each location after reading it, so the next frame starts from an empty image.
- Sits between the range-image BRAM (read port plus a second write port) and downstream consumers such as DMA packers and filters.

Parameters:
- IMG_W, 2048, pixels per row (x range 0..IMG_W-1).
- IMG_H, 128, rows per frame (y range 0..IMG_H-1); IMG_W*IMG_H ≤ 2^19.
- RD_LAT, 2, BRAM read latency in cycles (1 or 2).
- BUF_DEPTH, 4, output buffer entries; must be ≥ RD_LAT+1 and a power of 2.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_start, input, 1, one-cycle pulse that begins a frame scan; ignored while o_busy=1.
- i_clear_en, input, 1, sampled at accepted start; 1 = write 0 to each pixel after it is read.
- o_busy, output, 1, high from the cycle after start is accepted until the cycle o_done pulses.
- o_done, output, 1, one-cycle pulse when the last pixel is handshaked.
- o_rd_bram, output, 1, BRAM read enable.
- o_rAddress, output, 19, BRAM read address = y*IMG_W + x.
- i_rdata, input, 16, BRAM read data, valid RD_LAT cycles after o_rd_bram.
- o_wr_bram, output, 1, BRAM clear write enable.
- o_wAddress, output, 19, clear write address.
- o_wdata, output, 16, clear write data; constant 0.
- o_valid, output, 1, output pixel valid.
- i_ready, input, 1, downstream ready.
- o_x, output, 16, pixel column.
- o_y, output, 8, pixel row.
- o_r, output, 16, pixel range.
- o_eol, output, 1, pixel is x = IMG_W-1.
- o_eof, output, 1, pixel is the last of the frame (x = IMG_W-1, y = IMG_H-1).

Behaviour:
- **Reset.** All outputs reset to 0. State = IDLE. Counters, tag pipeline and buffer are cleared. Reset mid-scan abandons the frame: no further reads, writes or o_valid after reset; no o_done.
- **FSM states:** IDLE, SCAN, DRAIN.
  - IDLE → SCAN on i_start. The x/y issue counters are set to 0 and i_clear_en is latched.
  - SCAN → DRAIN in the cycle the read for the last pixel is issued.
  - DRAIN → IDLE in the cycle the eof pixel is handshaked (o_valid & i_ready & o_eof). o_done pulses in that same cycle.
  - o_busy = (state != IDLE), registered. It goes high the cycle after i_start and low the cycle after o_done.
- **Read issue.**
  - In SCAN, o_rd_bram=1 when (reads in flight + buffer occupancy) < BUF_DEPTH.
  - o_rAddress = y*IMG_W + x, computed from the counters. Use a running row base, not a multiplier.
  - The x counter increments per issued read. On wrap to 0, y increments.
  - The read for (x, y) is never reissued; no pixel is skipped or duplicated.
- **Tag pipeline.** x, y, eol and eof are delayed RD_LAT stages alongside each read. The buffer is pushed with {x, y, i_rdata, eol, eof} when the delayed valid arrives.
- **Credit rule.** Because of the in-flight limit, a buffer push never overflows, even if i_ready=0 for arbitrarily long.
- **Clear.**
  - If the clear is latched, o_wr_bram=1 in the same cycle as the buffer push, with o_wAddress = the address of that pixel and o_wdata=0.
  - The write always follows the read of the same address.
  - No write is issued when the clear is not latched.
- **Output.**
  - o_valid = buffer not empty. Outputs show the buffer head.
  - The head pops on o_valid & i_ready.
  - Outputs stay stable while o_valid=1 and i_ready=0.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty.
- **Throughput.** With i_ready held high, one pixel per cycle. The first o_valid appears RD_LAT+1 cycles after the first o_rd_bram (buffer registered). A frame completes in IMG_W*IMG_H + RD_LAT + 2 cycles from start.
- **Simultaneous events.**
  - i_start in the same cycle as o_done is ignored, because state is not IDLE.
  - i_start in the cycle after o_done is accepted.

Test Plan (IMG_W=4, IMG_H=2, RD_LAT=2, BUF_DEPTH=4; BRAM model preloaded with addr*3+1):
- **Full frame, ready always high.** Start with clear_en=0 → 8 pixels with (x, y, r) = (0,0,1), (1,0,4) … (3,1,22). o_eol on x=3 pixels only. o_eof and o_done on the 8th handshake. No o_wr_bram.
- **Backpressure.** i_ready low for 10 cycles from the first o_valid, then toggled 1/0 → outputs held stable while stalled. Reads stop once 4 entries are outstanding. Same 8-pixel sequence with no loss or duplication.
- **Clear mode.** Start with clear_en=1 → o_wr_bram pulses 8 times at addresses 0..7 with data 0, each at or after its read. A second scan returns r=0 for all pixels.
- **Start while busy.** i_start pulsed mid-frame and in the o_done cycle → ignored, exactly 8 pixels emitted. A start one cycle after o_done begins a new frame.
- **Reset mid-operation.** i_rst asserted after 3 handshakes with the buffer non-empty → the next cycle has o_valid=0, o_busy=0, no reads or writes. A fresh start restarts from (0,0).
- **RD_LAT=1 variant.** Full frame with ready high → first o_valid 2 cycles after the first read. Frame done in 11 cycles from start.

Source files
------------

// File: rtl/range_image_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : range_image_reader
//  Purpose  : Scans the range-image BRAM in row-major order after a start
//             pulse and streams every pixel as (x, y, range) on a valid/ready
//             interface with end-of-row / end-of-frame markers. Optionally
//             writes 0 back to each location once it has been read.
//  Ports    : i_clk, i_rst (sync, active high)
//             i_start, i_clear_en      - frame control
//             o_busy, o_done           - frame status
//             o_rd_bram, o_rAddress,
//             i_rdata                  - BRAM read port (RD_LAT latency)
//             o_wr_bram, o_wAddress,
//             o_wdata                  - BRAM clear write port
//             o_valid, i_ready, o_x, o_y, o_r, o_eol, o_eof - pixel stream
//  Revision : 1.0 - initial release
// ============================================================================
module range_image_reader #(
  parameter int IMG_W     = 2048,
  parameter int IMG_H     = 128,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_clear_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_rd_bram,
  output logic [18:0] o_rAddress,
  input  logic [15:0] i_rdata,
  output logic        o_wr_bram,
  output logic [18:0] o_wAddress,
  output logic [15:0] o_wdata,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_x,
  output logic [7:0]  o_y,
  output logic [15:0] o_r,
  output logic        o_eol,
  output logic        o_eof
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q;
  logic        clr_q, clr_d;
  logic [15:0] x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [18:0] base_q, base_d;   // running y*IMG_W

  logic        w_issue, w_last_col, w_last_pix, w_push, w_pop;
  logic [18:0] w_raddr;
  logic [7:0]  w_inflight;

  // Tag pipeline travelling alongside each outstanding read
  logic [RD_LAT-1:0]        tv_q, teol_q, teof_q;
  logic [RD_LAT-1:0][15:0]  tx_q;
  logic [RD_LAT-1:0][7:0]   ty_q;
  logic [RD_LAT-1:0][18:0]  tad_q;

  // Output buffer (circular)
  logic [BUF_DEPTH-1:0][15:0] bx_q, br_q;
  logic [BUF_DEPTH-1:0][7:0]  by_q;
  logic [BUF_DEPTH-1:0]       beol_q, beof_q;
  logic [PW-1:0]              wp_q, rp_q;
  logic [CW-1:0]              cnt_q;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + 8'(tv_q[i]);
    end
  end

  // Credit check: a read is only issued when a buffer slot is guaranteed for
  // it, counting reads still in the BRAM pipe as already occupying a slot.
  assign w_issue    = (state_q == ST_SCAN) && ((w_inflight + 8'(cnt_q)) < 8'(BUF_DEPTH));
  assign w_last_col = (x_q == 16'(IMG_W - 1));
  assign w_last_pix = w_last_col && (y_q == 8'(IMG_H - 1));
  assign w_raddr    = base_q + 19'(x_q);
  assign w_push     = tv_q[RD_LAT-1];
  assign w_pop      = o_valid && i_ready;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    clr_d   = clr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_SCAN;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          clr_d   = i_clear_en;
        end
      end
      ST_SCAN: begin
        if (w_issue) begin
          if (w_last_col) begin
            x_d    = '0;
            y_d    = y_q + 8'd1;
            base_d = base_q + 19'(IMG_W);
          end else begin
            x_d = x_q + 16'd1;
          end
          if (w_last_pix) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (w_pop && o_eof) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      clr_q   <= clr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tv_q   <= '0;
      teol_q <= '0;
      teof_q <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
      tad_q  <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      br_q   <= '0;
      beol_q <= '0;
      beof_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
    end else begin
      tv_q[0]   <= w_issue;
      teol_q[0] <= w_last_col;
      teof_q[0] <= w_last_pix;
      tx_q[0]   <= x_q;
      ty_q[0]   <= y_q;
      tad_q[0]  <= w_raddr;
      for (int i = 1; i < RD_LAT; i++) begin
        tv_q[i]   <= tv_q[i-1];
        teol_q[i] <= teol_q[i-1];
        teof_q[i] <= teof_q[i-1];
        tx_q[i]   <= tx_q[i-1];
        ty_q[i]   <= ty_q[i-1];
        tad_q[i]  <= tad_q[i-1];
      end
      // Writing wp_q while full is only possible with a same-cycle pop, in
      // which case the slot being overwritten is the head leaving this cycle.
      if (w_push) begin
        bx_q[wp_q]   <= tx_q[RD_LAT-1];
        by_q[wp_q]   <= ty_q[RD_LAT-1];
        br_q[wp_q]   <= i_rdata;
        beol_q[wp_q] <= teol_q[RD_LAT-1];
        beof_q[wp_q] <= teof_q[RD_LAT-1];
        wp_q         <= wp_q + PW'(1);
      end
      if (w_pop) begin
        rp_q <= rp_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = w_pop && o_eof && (state_q == ST_DRAIN);
  assign o_rd_bram  = w_issue;
  assign o_rAddress = w_raddr;
  // Clear write lands with the push, i.e. strictly after the read returned.
  assign o_wr_bram  = w_push && clr_q;
  assign o_wAddress = tad_q[RD_LAT-1];
  assign o_wdata    = '0;
  assign o_valid    = (cnt_q != '0);
  assign o_x        = bx_q[rp_q];
  assign o_y        = by_q[rp_q];
  assign o_r        = br_q[rp_q];
  assign o_eol      = beol_q[rp_q];
  assign o_eof      = beof_q[rp_q];

endmodule
`default_nettype wire

// File: tb/tb_range_image_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_range_image_reader
//  Purpose  : Directed self-checking bench for range_image_reader on a 4x2
//             image. Two instances share the control inputs: RD_LAT=2 (main)
//             and RD_LAT=1. Each has its own BRAM model preloaded with
//             addr*3+1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_range_image_reader;

  logic clk, rst, start, clear_en, ready, load, sel;

  logic        busy0, done0, rd0, wr0, valid0, eol0, eof0;
  logic [18:0] ra0, wa0;
  logic [15:0] wd0, rdata0, x0, r0;
  logic [7:0]  y0;
  logic        busy1, done1, rd1, wr1, valid1, eol1, eof1;
  logic [18:0] ra1, wa1;
  logic [15:0] wd1, rdata1, x1, r1;
  logic [7:0]  y1;

  range_image_reader #(.IMG_W(4), .IMG_H(2), .RD_LAT(2), .BUF_DEPTH(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear_en(clear_en),
    .o_busy(busy0), .o_done(done0), .o_rd_bram(rd0), .o_rAddress(ra0),
    .i_rdata(rdata0), .o_wr_bram(wr0), .o_wAddress(wa0), .o_wdata(wd0),
    .o_valid(valid0), .i_ready(ready), .o_x(x0), .o_y(y0), .o_r(r0),
    .o_eol(eol0), .o_eof(eof0));

  range_image_reader #(.IMG_W(4), .IMG_H(2), .RD_LAT(1), .BUF_DEPTH(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear_en(clear_en),
    .o_busy(busy1), .o_done(done1), .o_rd_bram(rd1), .o_rAddress(ra1),
    .i_rdata(rdata1), .o_wr_bram(wr1), .o_wAddress(wa1), .o_wdata(wd1),
    .o_valid(valid1), .i_ready(ready), .o_x(x1), .o_y(y1), .o_r(r1),
    .o_eol(eol1), .o_eof(eof1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM models
  logic [7:0][15:0] mem0, mem1;
  logic [15:0] s0a, s0b, s1a;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        mem0[i] <= 16'(3 * i + 1);
        mem1[i] <= 16'(3 * i + 1);
      end
    end else begin
      if (wr0) mem0[wa0[2:0]] <= wd0;
      if (wr1) mem1[wa1[2:0]] <= wd1;
    end
    if (rd0) s0a <= mem0[ra0[2:0]];
    s0b <= s0a;
    if (rd1) s1a <= mem1[ra1[2:0]];
  end
  assign rdata0 = s0b;
  assign rdata1 = s1a;

  // Observed instance
  logic        m_busy, m_done, m_rd, m_wr, m_valid;
  logic [18:0] m_ra, m_wa;
  logic [15:0] m_wd;
  logic [41:0] m_pix;
  assign m_busy  = sel ? busy1  : busy0;
  assign m_done  = sel ? done1  : done0;
  assign m_rd    = sel ? rd1    : rd0;
  assign m_wr    = sel ? wr1    : wr0;
  assign m_valid = sel ? valid1 : valid0;
  assign m_ra    = sel ? ra1    : ra0;
  assign m_wa    = sel ? wa1    : wa0;
  assign m_wd    = sel ? wd1    : wd0;
  assign m_pix   = sel ? {x1, y1, r1, eol1, eof1} : {x0, y0, r0, eol0, eof0};

  int errors = 0;
  int checks = 0;

  // Per-frame observations
  logic [41:0] pix [16];
  int wr_addr [16];
  int npix, ndone, done_cyc, first_rd, first_valid, nrd, nwr, wr_bad;
  int stab_bad, rd_at_stall, busy_low;
  logic busy1st;

  function automatic logic [41:0] exp_pix(input int k, input logic [15:0] r);
    exp_pix = {16'(k % 4), 8'(k / 4), r, (k % 4 == 3), (k == 7)};
  endfunction

  task automatic load_mem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  // Runs one frame on the selected instance and records what it saw.
  // Cycle c's inputs are set at negedge c and sampled at the edge ending c;
  // cycle 0 is the start cycle. mode 0: ready high; mode 1: ready low for 10
  // cycles from first valid, then alternating 1/0. s1/s2: extra start cycles.
  task automatic run_frame(input bit do_start, input bit clr, input int mode,
                           input int s1, input int s2);
    logic stalled;
    logic [41:0] snap;
    logic [7:0] rmask;
    for (int i = 0; i < 16; i++) begin pix[i] = '1; wr_addr[i] = -1; end
    npix = 0; ndone = 0; done_cyc = -1; first_rd = -1; first_valid = -1;
    nrd = 0; nwr = 0; wr_bad = 0; stab_bad = 0; rd_at_stall = -1;
    busy_low = -1; busy1st = 1'b0; stalled = 1'b0; snap = '0; rmask = '0;
    if (do_start) begin
      @(negedge clk);
      clear_en = clr; start = 1'b1; ready = (mode == 0);
    end
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = (c == s1) || (c == s2);
      if (mode == 1)
        ready = (first_valid >= 0) && (c - first_valid >= 10) && ((c - first_valid) % 2 == 0);
      #1;
      if (c == 1) busy1st = m_busy;
      if (m_wr) begin
        if (nwr < 16) wr_addr[nwr] = int'(m_wa);
        if (m_wd != 16'd0 || !rmask[m_wa[2:0]]) wr_bad++;
        nwr++;
      end
      if (m_rd) begin
        rmask[m_ra[2:0]] = 1'b1;
        nrd++;
        if (first_rd < 0) first_rd = c;
      end
      if (stalled && (m_pix !== snap)) stab_bad++;
      stalled = m_valid && !ready;
      snap = m_pix;
      if (m_valid && first_valid < 0) first_valid = c;
      if (mode == 1 && first_valid >= 0 && c - first_valid == 9) rd_at_stall = nrd;
      if (m_valid && ready) begin
        if (npix < 16) pix[npix] = m_pix;
        npix++;
      end
      if (m_done) begin ndone++; done_cyc = c; end
      if (!m_busy && c > 1) begin busy_low = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy0, done0, rd0, wr0, valid0, eol0, eof0, ra0, wa0, wd0, x0, y0, r0} !== '0) begin
      errors++;
      $display("FAIL reset_dut0: got %h expected 0",
               {busy0, done0, rd0, wr0, valid0, eol0, eof0, ra0, wa0, wd0, x0, y0, r0});
    end
    checks++;
    if ({busy1, done1, rd1, wr1, valid1, eol1, eof1, ra1, wa1, wd1, x1, y1, r1} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: got %h expected 0",
               {busy1, done1, rd1, wr1, valid1, eol1, eof1, ra1, wa1, wd1, x1, y1, r1});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    load_mem();
    run_frame(1'b1, 1'b0, 0, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix[k] !== exp_pix(k, 16'(3 * k + 1))) begin
        errors++;
        $display("FAIL full_pix%0d: got %h expected %h", k, pix[k], exp_pix(k, 16'(3 * k + 1)));
      end
    end
    checks++; if (npix !== 8) begin errors++; $display("FAIL full_npix: got %0d expected 8", npix); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL full_ndone: got %0d expected 1", ndone); end
    checks++; if (done_cyc !== 11) begin errors++; $display("FAIL full_done_cyc: got %0d expected 11", done_cyc); end
    checks++; if (first_rd !== 1) begin errors++; $display("FAIL full_first_rd: got %0d expected 1", first_rd); end
    checks++; if (first_valid - first_rd !== 3) begin errors++; $display("FAIL full_latency: got %0d expected 3", first_valid - first_rd); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL full_no_wr: got %0d expected 0", nwr); end
    checks++; if (busy1st !== 1'b1) begin errors++; $display("FAIL full_busy_rise: got %b expected 1", busy1st); end
    checks++; if (busy_low !== 12) begin errors++; $display("FAIL full_busy_low: got %0d expected 12", busy_low); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_frame(1'b1, 1'b0, 1, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix[k] !== exp_pix(k, 16'(3 * k + 1))) begin
        errors++;
        $display("FAIL bp_pix%0d: got %h expected %h", k, pix[k], exp_pix(k, 16'(3 * k + 1)));
      end
    end
    checks++; if (npix !== 8) begin errors++; $display("FAIL bp_npix: got %0d expected 8", npix); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stab_bad); end
    checks++; if (rd_at_stall !== 4) begin errors++; $display("FAIL bp_reads_stalled: got %0d expected 4", rd_at_stall); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL bp_ndone: got %0d expected 1", ndone); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL bp_no_wr: got %0d expected 0", nwr); end
    ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear();
    sel = 1'b0;
    run_frame(1'b1, 1'b1, 0, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix[k] !== exp_pix(k, 16'(3 * k + 1))) begin
        errors++;
        $display("FAIL clr_pix%0d: got %h expected %h", k, pix[k], exp_pix(k, 16'(3 * k + 1)));
      end
      checks++;
      if (wr_addr[k] !== k) begin
        errors++;
        $display("FAIL clr_waddr%0d: got %0d expected %0d", k, wr_addr[k], k);
      end
    end
    checks++; if (nwr !== 8) begin errors++; $display("FAIL clr_nwr: got %0d expected 8", nwr); end
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL clr_wr_order: got %0d bad writes expected 0", wr_bad); end
    repeat (3) @(negedge clk);
    run_frame(1'b1, 1'b0, 0, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix[k] !== exp_pix(k, 16'd0)) begin
        errors++;
        $display("FAIL clr_rescan%0d: got %h expected %h", k, pix[k], exp_pix(k, 16'd0));
      end
    end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL clr_rescan_wr: got %0d expected 0", nwr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_busy();
    int act;
    sel = 1'b0;
    load_mem();
    run_frame(1'b1, 1'b0, 0, 5, 11);
    checks++; if (npix !== 8) begin errors++; $display("FAIL sb_npix: got %0d expected 8", npix); end
    checks++; if (done_cyc !== 11) begin errors++; $display("FAIL sb_done_cyc: got %0d expected 11", done_cyc); end
    checks++; if (busy_low !== 12) begin errors++; $display("FAIL sb_busy_low: got %0d expected 12", busy_low); end
    act = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (busy0 || rd0 || valid0) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL sb_idle_after: got %0d active cycles expected 0", act); end
    // Start in the cycle right after o_done opens a new frame
    run_frame(1'b1, 1'b0, 0, -1, 12);
    checks++; if (done_cyc !== 11) begin errors++; $display("FAIL sb2_done_cyc: got %0d expected 11", done_cyc); end
    run_frame(1'b0, 1'b0, 0, -1, -1);
    checks++; if (first_rd !== 1) begin errors++; $display("FAIL sb2_first_rd: got %0d expected 1", first_rd); end
    checks++; if (npix !== 8) begin errors++; $display("FAIL sb2_npix: got %0d expected 8", npix); end
    checks++; if (pix[0] !== exp_pix(0, 16'd1)) begin errors++; $display("FAIL sb2_pix0: got %h expected %h", pix[0], exp_pix(0, 16'd1)); end
    checks++; if (pix[7] !== exp_pix(7, 16'd22)) begin errors++; $display("FAIL sb2_pix7: got %h expected %h", pix[7], exp_pix(7, 16'd22)); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int hs;
    sel = 1'b0;
    hs = 0;
    @(negedge clk);
    clear_en = 1'b0; start = 1'b1; ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid0 && ready) hs++;
      if (hs == 3) break;
    end
    checks++; if (hs !== 3) begin errors++; $display("FAIL rm_handshakes: got %0d expected 3", hs); end
    @(negedge clk);
    ready = 1'b0; rst = 1'b1;
    #1;
    checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL rm_buf_nonempty: got %b expected 1", valid0); end
    @(negedge clk); #1;
    checks++;
    if ({valid0, busy0, rd0, wr0, done0} !== 5'b0) begin
      errors++;
      $display("FAIL rm_after_reset: got %b expected 00000", {valid0, busy0, rd0, wr0, done0});
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({valid0, busy0, rd0, wr0, done0} !== 5'b0) begin
      errors++;
      $display("FAIL rm_quiet: got %b expected 00000", {valid0, busy0, rd0, wr0, done0});
    end
    run_frame(1'b1, 1'b0, 0, -1, -1);
    checks++; if (npix !== 8) begin errors++; $display("FAIL rm_npix: got %0d expected 8", npix); end
    checks++; if (pix[0] !== exp_pix(0, 16'd1)) begin errors++; $display("FAIL rm_pix0: got %h expected %h", pix[0], exp_pix(0, 16'd1)); end
    checks++; if (pix[7] !== exp_pix(7, 16'd22)) begin errors++; $display("FAIL rm_pix7: got %h expected %h", pix[7], exp_pix(7, 16'd22)); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rd_lat1();
    sel = 1'b1;
    load_mem();
    run_frame(1'b1, 1'b0, 0, -1, -1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix[k] !== exp_pix(k, 16'(3 * k + 1))) begin
        errors++;
        $display("FAIL lat1_pix%0d: got %h expected %h", k, pix[k], exp_pix(k, 16'(3 * k + 1)));
      end
    end
    checks++; if (first_valid - first_rd !== 2) begin errors++; $display("FAIL lat1_latency: got %0d expected 2", first_valid - first_rd); end
    checks++; if (done_cyc !== 10) begin errors++; $display("FAIL lat1_done_cyc: got %0d expected 10", done_cyc); end
    checks++; if (busy_low !== 11) begin errors++; $display("FAIL lat1_frame_cycles: got %0d expected 11", busy_low); end
    sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_en = 1'b0; ready = 1'b1; load = 1'b0; sel = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_clear();
    test_start_busy();
    test_reset_mid();
    test_rd_lat1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
